// File: rtl/fifo_mon_pkg.sv
// Shared types and error-bit indices for the synchronous FIFO monitor.
package fifo_mon_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } mon_state_t;

    localparam int ERR_W = 9;

    localparam int ERR_FULL     = 0;
    localparam int ERR_EMPTY    = 1;
    localparam int ERR_AF       = 2;
    localparam int ERR_AE       = 3;
    localparam int ERR_OVF      = 4;
    localparam int ERR_UNF      = 5;
    localparam int ERR_FULL_AF  = 6;
    localparam int ERR_EMPTY_AE = 7;
    localparam int ERR_DATA     = 8;

endpackage

// File: rtl/fifo_mon_shadow_mem.sv
// Shadow copy of the monitored FIFO's contents; flags a read whose data differs
// from the word recorded when it was written.
module fifo_mon_shadow_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  mismatch_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;

    // Pointers are exactly log2(depth) bits, so they wrap without extra logic.
    assign wr_ptr_d = wr_ptr_q + PTR_W'(wr_en_i);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(rd_en_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign mismatch_o = rd_en_i & (rd_data_i != mem_q[rd_ptr_q]);

endmodule

// File: rtl/sync_fifo_monitor.sv
// Shadow-occupancy protocol and flag checker for a synchronous FWFT FIFO.
// Define FIFO_MON_DATA_CHECK_EN to add the read-data comparison (err_flags[8]).
module sync_fifo_monitor
    import fifo_mon_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 256,
    parameter int AF_THRESH     = FIFO_DEPTH - 16,
    parameter int AE_THRESH     = 16,
    parameter int ERR_CNT_WIDTH = 16,
    parameter int STOP_ON_ERROR = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         read_en,
    input  logic [DATA_WIDTH-1:0]        data_out,
    input  logic                         full,
    input  logic                         almost_full,
    input  logic                         empty,
    input  logic                         almost_empty,
    input  logic                         clear_err,
    output logic [$clog2(FIFO_DEPTH):0]  occupancy,
    output logic [ERR_W-1:0]             err_flags,
    output logic [ERR_CNT_WIDTH-1:0]     err_count,
    output logic                         halted
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    mon_state_t               state_q, state_d;
    logic [CNT_W-1:0]         occ_q, occ_d;
    logic [ERR_W-1:0]         err_q, err_d, err_now;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic wr_acc, rd_acc, run, any_err, data_mismatch;
    logic exp_full, exp_empty, exp_af, exp_ae;

    assign wr_acc = write_en & ~full;
    assign rd_acc = read_en & ~empty;
    assign run    = (state_q == RUN);

    assign exp_full  = (occ_q == DEPTH_C);
    assign exp_empty = (occ_q == '0);
    assign exp_af    = (occ_q >= AF_C);
    assign exp_ae    = (occ_q <= AE_C);

`ifdef FIFO_MON_DATA_CHECK_EN
    fifo_mon_shadow_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_shadow_mem (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (run & wr_acc),
        .wr_data_i  (data_in),
        .rd_en_i    (run & rd_acc),
        .rd_data_i  (data_out),
        .mismatch_o (data_mismatch)
    );
`else
    logic unused_data;
    assign data_mismatch = 1'b0;
    assign unused_data   = ^{data_in, data_out};
`endif

    // NOTE: every output of this block gets a default first, so no latches form.
    always_comb begin
        err_now = '0;
        if (run) begin
            err_now[ERR_FULL]     = (full != exp_full);
            err_now[ERR_EMPTY]    = (empty != exp_empty);
            err_now[ERR_AF]       = (almost_full != exp_af);
            err_now[ERR_AE]       = (almost_empty != exp_ae);
            err_now[ERR_OVF]      = write_en & full;
            err_now[ERR_UNF]      = read_en & empty;
            err_now[ERR_FULL_AF]  = full & ~almost_full;
            err_now[ERR_EMPTY_AE] = empty & ~almost_empty;
            err_now[ERR_DATA]     = data_mismatch;
        end
    end

    assign any_err = |err_now;

    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        err_d   = clear_err ? '0 : err_q;
        cnt_d   = clear_err ? '0 : cnt_q;

        // A new error outranks a same-cycle clear: bit set, count restarts at 1.
        if (any_err) begin
            err_d = err_d | err_now;
            if (cnt_d != '1) begin
                cnt_d = cnt_d + ERR_CNT_WIDTH'(1);
            end
        end

        unique case (state_q)
            INIT: if (empty) state_d = RUN;
            RUN: begin
                occ_d = occ_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
                if ((STOP_ON_ERROR != 0) && any_err) state_d = HALT;
            end
            HALT: state_d = HALT;
            default: state_d = INIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            occ_q   <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign occupancy = occ_q;
    assign err_flags = err_q;
    assign err_count = cnt_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_sync_fifo_monitor.sv
// Directed bench for sync_fifo_monitor: a STOP_ON_ERROR=0 instance for the
// counting/flag checks and a STOP_ON_ERROR=1 instance for the HALT behaviour.
module tb_sync_fifo_monitor;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- main instance (STOP_ON_ERROR = 0) ----------------
    logic       reset, write_en, read_en, clear_err;
    logic [7:0] data_in, data_out;
    logic       full, almost_full, empty, almost_empty;
    logic [8:0] occupancy, err_flags;
    logic [15:0] err_count;
    logic       halted;

    sync_fifo_monitor #(.STOP_ON_ERROR(0)) dut (
        .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in),
        .read_en(read_en), .data_out(data_out), .full(full),
        .almost_full(almost_full), .empty(empty), .almost_empty(almost_empty),
        .clear_err(clear_err), .occupancy(occupancy), .err_flags(err_flags),
        .err_count(err_count), .halted(halted)
    );

    // ---------------- halting instance (STOP_ON_ERROR = 1) -------------
    logic       h_reset, h_write_en, h_read_en, h_clear_err;
    logic       h_full, h_af, h_empty, h_ae;
    logic [8:0] h_occupancy, h_err_flags;
    logic [15:0] h_err_count;
    logic       h_halted;

    sync_fifo_monitor #(.STOP_ON_ERROR(1)) dut_halt (
        .clk(clk), .reset(h_reset), .write_en(h_write_en), .data_in(8'h00),
        .read_en(h_read_en), .data_out(8'h00), .full(h_full),
        .almost_full(h_af), .empty(h_empty), .almost_empty(h_ae),
        .clear_err(h_clear_err), .occupancy(h_occupancy), .err_flags(h_err_flags),
        .err_count(h_err_count), .halted(h_halted)
    );

    // Bench-side FIFO model: count and contents drive correct flags/data
    int         m_cnt = 0;
    logic [7:0] m_q[$];
    logic [3:0] ovr_en  = 4'b0000;   // {full, af, empty, ae} override enables
    logic [3:0] ovr_val = 4'b0000;
    logic [7:0] dout_xor = 8'h00;

    task automatic step(input logic wr, input logic rd, input logic [7:0] din, input logic clr);
        logic [3:0] f;
        @(negedge clk);
        f = {m_cnt == 256, m_cnt >= 240, m_cnt == 0, m_cnt <= 16};
        f = (f & ~ovr_en) | (ovr_val & ovr_en);
        {full, almost_full, empty, almost_empty} = f;
        write_en  = wr;
        read_en   = rd;
        data_in   = din;
        data_out  = ((m_q.size() > 0) ? m_q[0] : 8'h00) ^ dout_xor;
        clear_err = clr;
        @(posedge clk);
        #1;
        if (rd && !f[1]) begin m_cnt--; void'(m_q.pop_front()); end
        if (wr && !f[3]) begin m_cnt++; m_q.push_back(din); end
    endtask

    task automatic test_reset;
        reset = 1'b1; write_en = 1'b0; read_en = 1'b0; clear_err = 1'b0;
        data_in = 8'h00; data_out = 8'h00;
        full = 1'b0; almost_full = 1'b0; empty = 1'b1; almost_empty = 1'b1;
        #12;
        if (occupancy !== 9'd0) begin $display("FAIL reset_occ: got %0d want 0", occupancy); miscompares++; end
        vectors++;
        if (err_flags !== 9'h000) begin $display("FAIL reset_flags: got %h want 000", err_flags); miscompares++; end
        vectors++;
        if (err_count !== 16'd0) begin $display("FAIL reset_cnt: got %0d want 0", err_count); miscompares++; end
        vectors++;
        if (halted !== 1'b0) begin $display("FAIL reset_halted: got %b want 0", halted); miscompares++; end
        vectors++;
    endtask

    // FIFO reports not-empty out of reset: monitor must wait in INIT, unchecked
    task automatic test_init_hold;
        @(negedge clk);
        reset = 1'b0; empty = 1'b0; almost_empty = 1'b1; write_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (occupancy !== 9'd0) begin $display("FAIL init_occ: got %0d want 0", occupancy); miscompares++; end
        vectors++;
        if (err_flags !== 9'h000) begin $display("FAIL init_flags: got %h want 000", err_flags); miscompares++; end
        vectors++;
        step(1'b0, 1'b0, 8'h00, 1'b0);   // empty=1 here: INIT -> RUN
    endtask

    task automatic test_fill;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            if (i == 239) begin
                if (occupancy !== 9'd240) begin $display("FAIL fill_occ240: got %0d want 240", occupancy); miscompares++; end
                vectors++;
            end
        end
        if (occupancy !== 9'd256) begin $display("FAIL fill_occ: got %0d want 256", occupancy); miscompares++; end
        vectors++;
        if (err_flags !== 9'h000) begin $display("FAIL fill_flags: got %h want 000", err_flags); miscompares++; end
        vectors++;
        if (err_count !== 16'd0) begin $display("FAIL fill_cnt: got %0d want 0", err_count); miscompares++; end
        vectors++;
        if (halted !== 1'b0) begin $display("FAIL fill_halted: got %b want 0", halted); miscompares++; end
        vectors++;
    endtask

    task automatic test_almost_full;
        repeat (16) step(1'b0, 1'b1, 8'h00, 1'b0);
        if (occupancy !== 9'd240) begin $display("FAIL af_occ: got %0d want 240", occupancy); miscompares++; end
        vectors++;
        ovr_en = 4'b0100; ovr_val = 4'b0000;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        if (err_flags !== 9'h004) begin $display("FAIL af_flags: got %h want 004", err_flags); miscompares++; end
        vectors++;
        if (err_count !== 16'd1) begin $display("FAIL af_cnt1: got %0d want 1", err_count); miscompares++; end
        vectors++;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        if (err_count !== 16'd2) begin $display("FAIL af_cnt2: got %0d want 2", err_count); miscompares++; end
        vectors++;
        ovr_en = 4'b0000;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        if ({err_flags, err_count} !== 25'd0) begin $display("FAIL af_clear: got %h/%0d want 000/0", err_flags, err_count); miscompares++; end
        vectors++;
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i + 100), 1'b0);
        repeat (3) step(1'b1, 1'b0, 8'hEE, 1'b0);
        if (occupancy !== 9'd256) begin $display("FAIL ovf_occ: got %0d want 256", occupancy); miscompares++; end
        vectors++;
        if (err_flags !== 9'h010) begin $display("FAIL ovf_flags: got %h want 010", err_flags); miscompares++; end
        vectors++;
        if (err_count !== 16'd3) begin $display("FAIL ovf_cnt: got %0d want 3", err_count); miscompares++; end
        vectors++;
        step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_back_to_back;
        repeat (246) step(1'b0, 1'b1, 8'h00, 1'b0);
        if (occupancy !== 9'd10) begin $display("FAIL b2b_occ_pre: got %0d want 10", occupancy); miscompares++; end
        vectors++;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'h50 + i), 1'b0);
        if (occupancy !== 9'd10) begin $display("FAIL b2b_occ: got %0d want 10", occupancy); miscompares++; end
        vectors++;
        if ({err_flags, err_count} !== 25'd0) begin $display("FAIL b2b_err: got %h/%0d want 000/0", err_flags, err_count); miscompares++; end
        vectors++;
    endtask

    task automatic test_underflow_and_clear;
        repeat (10) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        if (occupancy !== 9'd0) begin $display("FAIL unf_occ: got %0d want 0", occupancy); miscompares++; end
        vectors++;
        if (err_flags !== 9'h020) begin $display("FAIL unf_flags: got %h want 020", err_flags); miscompares++; end
        vectors++;
        if (halted !== 1'b0) begin $display("FAIL unf_halted: got %b want 0", halted); miscompares++; end
        vectors++;
        // clear together with a new error (full wrongly high at count 0)
        ovr_en = 4'b1000; ovr_val = 4'b1000;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        if (err_flags !== 9'h041) begin $display("FAIL clr_new_flags: got %h want 041", err_flags); miscompares++; end
        vectors++;
        if (err_count !== 16'd1) begin $display("FAIL clr_new_cnt: got %0d want 1", err_count); miscompares++; end
        vectors++;
        ovr_en = 4'b0000; ovr_val = 4'b0000;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

`ifdef FIFO_MON_DATA_CHECK_EN
    task automatic test_data_check;
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        step(1'b1, 1'b0, 8'h3C, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        if (err_flags !== 9'h000) begin $display("FAIL data_rd1: got %h want 000", err_flags); miscompares++; end
        vectors++;
        dout_xor = 8'h01;                 // FIFO returns 0x3D instead of 0x3C
        step(1'b0, 1'b1, 8'h00, 1'b0);
        dout_xor = 8'h00;
        if (err_flags !== 9'h100) begin $display("FAIL data_rd2: got %h want 100", err_flags); miscompares++; end
        vectors++;
        if (err_count !== 16'd1) begin $display("FAIL data_cnt: got %0d want 1", err_count); miscompares++; end
        vectors++;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, 8'(i * 7 + 3), 1'b0);
            step(1'b0, 1'b1, 8'h00, 1'b0);
        end
        if ({err_flags, err_count} !== 25'd0) begin $display("FAIL data_wrap: got %h/%0d want 000/0", err_flags, err_count); miscompares++; end
        vectors++;
    endtask
`endif

    task automatic test_halt;
        @(negedge clk);
        h_reset = 1'b0; h_empty = 1'b1; h_ae = 1'b1; h_full = 1'b0; h_af = 1'b0;
        @(posedge clk); #1;               // INIT -> RUN
        @(negedge clk); h_read_en = 1'b1;
        @(posedge clk); #1;
        if (h_err_flags !== 9'h020) begin $display("FAIL halt_flags: got %h want 020", h_err_flags); miscompares++; end
        vectors++;
        if (h_halted !== 1'b1) begin $display("FAIL halt_halted: got %b want 1", h_halted); miscompares++; end
        vectors++;
        // wrong flags and handshakes while halted: nothing may change
        @(negedge clk); h_read_en = 1'b0; h_write_en = 1'b1; h_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (h_occupancy !== 9'd0) begin $display("FAIL halt_occ: got %0d want 0", h_occupancy); miscompares++; end
        vectors++;
        if (h_err_count !== 16'd1) begin $display("FAIL halt_cnt: got %0d want 1", h_err_count); miscompares++; end
        vectors++;
        @(negedge clk); h_write_en = 1'b0; h_empty = 1'b1; h_clear_err = 1'b1;
        @(posedge clk); #1;
        if ({h_err_flags, h_err_count} !== 25'd0) begin $display("FAIL halt_clear: got %h/%0d want 000/0", h_err_flags, h_err_count); miscompares++; end
        vectors++;
        if (h_halted !== 1'b1) begin $display("FAIL halt_stays: got %b want 1", h_halted); miscompares++; end
        vectors++;
        @(negedge clk); h_clear_err = 1'b0; h_reset = 1'b1;
        #1;
        if ({h_occupancy, h_err_flags, h_err_count, h_halted} !== 35'd0) begin
            $display("FAIL halt_reset: got occ %0d flags %h cnt %0d halted %b want all 0", h_occupancy, h_err_flags, h_err_count, h_halted);
            miscompares++;
        end
        vectors++;
        @(negedge clk); h_reset = 1'b0;
        @(posedge clk); #1;               // INIT -> RUN again
        @(negedge clk); h_write_en = 1'b1;
        @(posedge clk); #1;
        if (h_occupancy !== 9'd1) begin $display("FAIL halt_rerun_occ: got %0d want 1", h_occupancy); miscompares++; end
        vectors++;
        if (h_halted !== 1'b0) begin $display("FAIL halt_rerun_halted: got %b want 0", h_halted); miscompares++; end
        vectors++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        h_reset = 1'b1; h_write_en = 1'b0; h_read_en = 1'b0; h_clear_err = 1'b0;
        h_full = 1'b0; h_af = 1'b0; h_empty = 1'b1; h_ae = 1'b1;
        test_reset();
        test_init_hold();
        test_fill();
        test_almost_full();
        test_overflow();
        test_back_to_back();
        test_underflow_and_clear();
`ifdef FIFO_MON_DATA_CHECK_EN
        test_data_check();
`endif
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_fifo_monitor.md
Name: sync_fifo_monitor

Overview:
- Synthesizable, parametrised single-clock protocol and flag monitor for the team's synchronous FIFOs. It is the successor to the simulation-only flag assertions.
- Keeps a shadow occupancy count from the write/read handshakes and checks every FIFO status flag against it, using programmable almost-thresholds.
- Flags overflow/underflow attempts and reports sticky error bits plus an error counter, so the same checks run in simulation and in hardware debug builds.
- Instantiated alongside any FIFO under test; it only observes and never drives the FIFO.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out.
- FIFO_DEPTH, 256, number of entries in the monitored FIFO; power of two, >= 4.
- AF_THRESH, FIFO_DEPTH-16, almost_full expected when count >= AF_THRESH.
- AE_THRESH, 16, almost_empty expected when count <= AE_THRESH.
- ERR_CNT_WIDTH, 16, width of err_count; the counter saturates.
- STOP_ON_ERROR, 0, 1 = enter HALT on the first error.

Ports:
- clk  in  1  monitor clock; the same clock as the FIFO.
- reset  in  1  asynchronous, active-high reset.
- write_en  in  1  FIFO write request.
- data_in  in  DATA_WIDTH  FIFO write data.
- read_en  in  1  FIFO read request.
- data_out  in  DATA_WIDTH  FIFO read data; first-word-fall-through, valid while !empty.
- full, almost_full, empty, almost_empty  in  1 each  FIFO flags.
- clear_err  in  1  synchronous clear of err_flags and err_count.
- occupancy  out  $clog2(FIFO_DEPTH)+1  shadow count.
- err_flags  out  9  sticky error vector.
- err_count  out  ERR_CNT_WIDTH  number of cycles with any new error.
- halted  out  1  high in HALT.

Behaviour:
- Reset: state=INIT, occupancy=0, err_flags=0, err_count=0, halted=0. Asynchronous assert; release is seen on the next clk edge.
- Handshake definitions:
  - wr_acc = write_en & !full.
  - rd_acc = read_en & !empty.
  - On each edge: count += wr_acc - rd_acc. Simultaneous accepts leave count unchanged.
  - The count cannot exceed FIFO_DEPTH or drop below 0, because accepts are gated by the flags.
- Expected flags, derived combinationally from the registered count in the same cycle:
  - exp_full = (count == FIFO_DEPTH)
  - exp_empty = (count == 0)
  - exp_af = (count >= AF_THRESH)
  - exp_ae = (count <= AE_THRESH)
- Error bits; any condition true at an edge in RUN sets its bit, and bits are sticky:
  - [0] full != exp_full
  - [1] empty != exp_empty
  - [2] almost_full != exp_af
  - [3] almost_empty != exp_ae
  - [4] overflow attempt: write_en & full
  - [5] underflow attempt: read_en & empty
  - [6] full & !almost_full
  - [7] empty & !almost_empty
  - [8] data mismatch (optional feature); reads 0 when the feature is compiled out.
- err_count increments by 1 per cycle with any new error condition and saturates at all-ones.
- clear_err zeroes err_flags and err_count the same cycle. If an error is detected in that cycle, the new error wins: its bit is set and err_count=1.
- State machine:
  - INIT -> RUN on the first edge after reset release where empty=1. If empty=0 in INIT, stay in INIT and do no checks; handshakes are still ignored and occupancy holds 0.
  - RUN -> HALT when STOP_ON_ERROR=1 and any error is detected. Otherwise stay in RUN.
  - In HALT: occupancy is frozen, checks stop, halted=1. The only exit is reset; clear_err clears the flags but stays in HALT.
- Reset mid-operation returns to INIT immediately; all state is lost.

Optional Feature:
- Macro: FIFO_MON_DATA_CHECK_EN.
- When defined:
  - Adds a shadow memory of FIFO_DEPTH x DATA_WIDTH with its own write/read pointers of $clog2(FIFO_DEPTH) bits that wrap naturally.
  - On wr_acc, data_in is stored.
  - On rd_acc, data_out is compared with the shadow head; a mismatch sets err_flags[8] and counts as an error.
- When undefined: no memory is built and err_flags[8] is tied to 0.

Decomposition:
- Package fifo_mon_pkg holds:
  - typedef enum mon_state_t {INIT, RUN, HALT};
  - localparam ERR_W=9;
  - named bit indices ERR_FULL, ERR_EMPTY, ERR_AF, ERR_AE, ERR_OVF, ERR_UNF, ERR_FULL_AF, ERR_EMPTY_AE, ERR_DATA.
- Sub-module fifo_mon_shadow_mem holds the optional data-check storage and its pointers, and is instantiated only under the macro.

Test Plan:
- Reset, then empty=1: INIT->RUN. Write 256 words with correct flags -> occupancy=256, err_flags=0, halted=0.
- At occupancy=240 with almost_full held 0 -> err_flags[2]=1, err_count=1. Next cycle still wrong -> err_count=2.
- Full=1, write_en=1 for 3 cycles -> err_flags[4]=1, occupancy stays 256, err_count=3.
- Simultaneous write_en and read_en at occupancy=10 for 5 cycles -> occupancy stays 10, no errors.
- STOP_ON_ERROR=1, empty=1, read_en=1 -> err_flags[5]=1, halted=1 next cycle. Later handshakes do not change occupancy. Reset -> INIT, all outputs 0.
- With FIFO_MON_DATA_CHECK_EN: write 0xA5, 0x3C, then return 0xA5, 0x3D on reads -> err_flags[8]=1 on the second read only. Pointer wrap is verified by 300 write/read pairs with no error.
